// File: rtl/seven_seg_mux_n.sv
// Time-multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// Display data is double-buffered: loads land in a pending buffer and are
// promoted to the active buffer only when the scan wraps back to digit 0.
// Adds per-digit decimal point and blanking, leading-zero suppression and
// 16-level PWM brightness. All outputs are registered.
module seven_seg_mux_n #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV_BITS   = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  input  logic                    lz_en_i,
  input  logic [3:0]              bright_i,
  output logic [7:0]              digit_o,
  output logic [NUM_DIGITS-1:0]   segm_sel_o,
  output logic                    frame_start_o,
  output logic                    pend_o
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     presc_q;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    tick, wrap;

  logic [4*NUM_DIGITS-1:0] pen_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pen_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pen_blank_q, act_blank_q;
  logic                    pend_q, frame_start_q;

  logic [7:0]              digit_q, digit_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [3:0]              cur_nib;
  logic [7:0]              font;
  logic                    visible, pwm_on;

  // Slot timing: tick on the last prescaler count, wrap on the last digit.
  always_comb begin
    tick  = &presc_q;
    wrap  = tick && (idx_q == LastIdx);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
      idx_q   <= idx_d;
    end
  end

  // Double buffer: active takes the old pending contents at the wrap edge,
  // while a load on that same edge refills pending and keeps it flagged.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pen_data_q    <= '0;
      pen_dp_q      <= '0;
      pen_blank_q   <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      pend_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= wrap;
      if (wrap && pend_q) begin
        act_data_q  <= pen_data_q;
        act_dp_q    <= pen_dp_q;
        act_blank_q <= pen_blank_q;
        pend_q      <= 1'b0;
      end
      if (load_i) begin
        pen_data_q  <= data_i;
        pen_dp_q    <= dp_in_i;
        pen_blank_q <= blank_i;
        pend_q      <= 1'b1;
      end
    end
  end

  // upper_zero[k]: every nibble from k up to the most significant is zero.
  always_comb begin
    upper_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      upper_zero[k] = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (act_data_q[4*j +: 4] != 4'h0) begin
          upper_zero[k] = 1'b0;
        end
      end
    end
  end

  // Hex font, active-low segments a..g in [7:1], dp (off) in [0].
  always_comb begin
    cur_nib = act_data_q[{idx_q, 2'b00} +: 4];
    font    = 8'hFF;
    unique case (cur_nib)
      4'h0: font = 8'h03;
      4'h1: font = 8'h9F;
      4'h2: font = 8'h25;
      4'h3: font = 8'h0D;
      4'h4: font = 8'h99;
      4'h5: font = 8'h49;
      4'h6: font = 8'h41;
      4'h7: font = 8'h1F;
      4'h8: font = 8'h01;
      4'h9: font = 8'h09;
      4'hA: font = 8'h11;
      4'hB: font = 8'hC1;
      4'hC: font = 8'h63;
      4'hD: font = 8'h85;
      4'hE: font = 8'h61;
      4'hF: font = 8'h71;
    endcase
  end

  // Next outputs for the current slot; digit 0 is never zero-suppressed.
  always_comb begin
    visible = !act_blank_q[idx_q] &&
              !(lz_en_i && (idx_q != '0) && upper_zero[idx_q]);
    pwm_on  = presc_q[DIV_BITS-1 -: 4] < bright_i;
    sel_d   = '1;
    digit_d = 8'hFF;
    if (visible && pwm_on) begin
      sel_d   = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      digit_d = {font[7:1], ~act_dp_q[idx_q]};
    end
  end

  // Registered pin drivers; blank (all high) during reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sel_q   <= '1;
      digit_q <= 8'hFF;
    end else begin
      sel_q   <= sel_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o       = digit_q;
  assign segm_sel_o    = sel_q;
  assign frame_start_o = frame_start_q;
  assign pend_o        = pend_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Bench for seven_seg_mux_n (4 digits, 16-clock slots). A cycle-count based
// model predicts every output each clock; a vector table and a few directed
// sequences check specific display contents.
module tb_seven_seg_mux_n;

  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data;
  logic [3:0]  dp_in, blank, bright;
  logic        load, lz_en;
  logic [7:0]  digit;
  logic [3:0]  segm_sel;
  logic        frame_start, pend;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_mux_n #(
    .NUM_DIGITS(N),
    .DIV_BITS  (D)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .data_i       (data),
    .dp_in_i      (dp_in),
    .blank_i      (blank),
    .load_i       (load),
    .lz_en_i      (lz_en),
    .bright_i     (bright),
    .digit_o      (digit),
    .segm_sel_o   (segm_sel),
    .frame_start_o(frame_start),
    .pend_o       (pend)
  );

  logic [7:0] font [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Model state: clocks since reset plus the two buffers.
  int          m_cyc = 0;
  logic [15:0] m_act_data = '0, m_pen_data = '0;
  logic [3:0]  m_act_dp = '0, m_pen_dp = '0, m_act_bl = '0, m_pen_bl = '0;
  logic        m_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: predict outputs from pre-edge state and inputs, then compare.
  task automatic step();
    logic        r_n, ld, lz, vis, on, upz, e_fs;
    logic [15:0] d;
    logic [3:0]  dp, bl, br, nib, e_sel;
    logic [7:0]  e_dig;
    int          idx, pr;
    r_n = reset_n; ld = load; lz = lz_en; d = data; dp = dp_in; bl = blank; br = bright;
    if (!r_n) begin
      e_sel = 4'hF; e_dig = 8'hFF; e_fs = 1'b0;
      m_cyc = 0; m_pend = 1'b0;
      m_act_data = '0; m_pen_data = '0;
      m_act_dp = '0; m_pen_dp = '0; m_act_bl = '0; m_pen_bl = '0;
    end else begin
      idx = (m_cyc / 16) % 4;
      pr  = m_cyc % 16;
      nib = m_act_data[4*idx +: 4];
      upz = (m_act_data >> (4 * idx)) == 16'h0;
      vis = !m_act_bl[idx] && !(lz && idx != 0 && upz);
      on  = pr < int'(br);
      e_sel = (vis && on) ? ~(4'b0001 << idx) : 4'hF;
      e_dig = (vis && on) ? (font[nib] & ~{7'b0, m_act_dp[idx]}) : 8'hFF;
      e_fs  = (m_cyc % 64) == 63;
      if (e_fs && m_pend) begin
        m_act_data = m_pen_data; m_act_dp = m_pen_dp; m_act_bl = m_pen_bl;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_pen_data = d; m_pen_dp = dp; m_pen_bl = bl;
        m_pend = 1'b1;
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    check("segm_sel", 32'(segm_sel), 32'(e_sel));
    check("digit", 32'(digit), 32'(e_dig));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("pend", 32'(pend), 32'(m_pend));
  endtask

  // Run until a frame boundary that left nothing pending.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (frame_start === 1'b1 && pend === 1'b0) seen = 1'b1;
    end
    check("frame_timeout", 32'(seen), 32'd1);
  endtask

  typedef struct packed {
    logic [15:0]      data;
    logic [3:0]       dp;
    logic [3:0]       bl;
    logic             lz;
    logic [3:0]       br;
    logic [3:0][7:0]  dig;
    logic [3:0][3:0]  sel;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{16'h12AF, 4'b0010, 4'b0000, 1'b0, 4'd15,
                {8'h9F, 8'h25, 8'h10, 8'h71}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[1] = '{16'h0070, 4'b0000, 4'b0000, 1'b1, 4'd15,
                {8'hFF, 8'hFF, 8'h1F, 8'h03}, {4'b1111, 4'b1111, 4'b1101, 4'b1110}};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 4'd15,
                {8'hFF, 8'hFF, 8'hFF, 8'h03}, {4'b1111, 4'b1111, 4'b1111, 4'b1110}};
    vecs[3] = '{16'h0000, 4'b0000, 4'b0001, 1'b1, 4'd15,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {4'b1111, 4'b1111, 4'b1111, 4'b1111}};
    vecs[4] = '{16'h8888, 4'b0000, 4'b0000, 1'b0, 4'd0,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF}, {4'b1111, 4'b1111, 4'b1111, 4'b1111}};
    vecs[5] = '{16'h8888, 4'b0000, 4'b0000, 1'b0, 4'd4,
                {8'h01, 8'h01, 8'h01, 8'h01}, {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
    vecs[6] = '{16'h0E0B, 4'b1000, 4'b0000, 1'b1, 4'd15,
                {8'hFF, 8'h61, 8'h03, 8'hC1}, {4'b1111, 4'b1011, 4'b1101, 4'b1110}};

    reset_n = 1'b0; data = '0; dp_in = '0; blank = '0; load = 1'b0;
    lz_en = 1'b0; bright = 4'd15;

    // Reset state.
    repeat (3) step();
    check("rst_segm_sel", 32'(segm_sel), 32'hF);
    check("rst_digit", 32'(digit), 32'hFF);
    check("rst_pend", 32'(pend), 32'd0);
    reset_n = 1'b1;

    // Table: load, wait for it to become active, sample each slot at prescaler 0.
    for (int v = 0; v < 7; v++) begin
      data = vecs[v].data; dp_in = vecs[v].dp; blank = vecs[v].bl;
      lz_en = vecs[v].lz; bright = vecs[v].br;
      load = 1'b1;
      step();
      load = 1'b0;
      check("load_pend", 32'(pend), 32'd1);
      wait_frame();
      for (int k = 0; k < 4; k++) begin
        repeat ((k == 0) ? 1 : 16) step();
        check($sformatf("vec%0d_slot%0d_digit", v, k), 32'(digit), 32'(vecs[v].dig[k]));
        check($sformatf("vec%0d_slot%0d_sel", v, k), 32'(segm_sel), 32'(vecs[v].sel[k]));
      end
    end

    // Two loads in one frame: the last wins.
    lz_en = 1'b0; bright = 4'd15; blank = '0; dp_in = '0;
    wait_frame();
    repeat (5) step();
    data = 16'h1111; load = 1'b1; step(); load = 1'b0;
    repeat (7) step();
    data = 16'h2222; load = 1'b1; step(); load = 1'b0;
    check("multi_load_pend", 32'(pend), 32'd1);
    wait_frame();
    step();
    check("multi_load_digit", 32'(digit), 32'h25);

    // Load on the wrap edge: active keeps old contents, new data waits a frame.
    for (int i = 0; i < 80 && (m_cyc % 64) != 63; i++) step();
    data = 16'h3333; load = 1'b1; step(); load = 1'b0;
    check("wrap_load_fs", 32'(frame_start), 32'd1);
    check("wrap_load_pend", 32'(pend), 32'd1);
    step();
    check("wrap_load_old", 32'(digit), 32'h25);
    wait_frame();
    step();
    check("wrap_load_new", 32'(digit), 32'h0D);

    // Reset during the digit-2 slot discards a pending load.
    for (int i = 0; i < 80 && ((m_cyc / 16) % 4) != 1; i++) step();
    data = 16'h4444; load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 80 && ((m_cyc / 16) % 4) != 2; i++) step();
    repeat (3) step();
    reset_n = 1'b0;
    step();
    check("midrst_sel", 32'(segm_sel), 32'hF);
    check("midrst_digit", 32'(digit), 32'hFF);
    check("midrst_pend", 32'(pend), 32'd0);
    reset_n = 1'b1;
    step();
    check("postrst_digit", 32'(digit), 32'h03);
    check("postrst_sel", 32'(segm_sel), 32'b1110);

    // Randomized traffic checked every clock by the model.
    for (int i = 0; i < 4000; i++) begin
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        data  = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                 {4{$urandom_range(0, 1) == 1}}, {4{1'b1}}};
        dp_in = 4'($urandom);
        blank = 4'($urandom) & 4'($urandom);
      end
      if ($urandom_range(0, 99) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 199) == 0) bright = 4'($urandom);
      reset_n = ($urandom_range(0, 799) != 0);
      step();
    end
    reset_n = 1'b1; load = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_n.md
Name: seven_seg_mux_n

Overview:
Parametrised time-multiplexed seven-segment driver and successor to the fixed 4-digit scanner. It scans NUM_DIGITS hex digits with a programmable scan rate and double-buffers display data so that updates take effect only at frame boundaries. It adds per-digit decimal point and blanking, leading-zero suppression and 16-level PWM brightness. It sits between the ALU/register datapath and the board's common-anode display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
DIV_BITS, 16, prescaler width; one digit slot = 2^DIV_BITS clocks (min 4).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
data  in  4*NUM_DIGITS  hex value; nibble k drives digit k (nibble 0 = LSD)
dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit
blank  in  NUM_DIGITS  per-digit force-blank, 1 = blank
load  in  1  capture data/dp_in/blank into the pending buffer
lz_en  in  1  leading-zero suppression enable (live, not buffered)
bright  in  4  brightness 0..15 (live, not buffered)
digit  out  8  segments, active-low: [7]=a … [1]=g, [0]=dp
segm_sel  out  NUM_DIGITS  anode select, active-low one-hot; bit k = digit k
frame_start  out  1  one-cycle pulse after the active buffer is updated
pend  out  1  pending buffer holds data not yet displayed

Behaviour:
- Reset: all state updates on posedge clk while reset==0. Prescaler=0, index=0, active and pending buffers=0, pend=0, frame_start=0, segm_sel=all 1s, digit=8'hFF. Reset mid-scan aborts the slot immediately; a pending load is discarded.
- Prescaler: free-running DIV_BITS counter. tick = (prescaler == all 1s), combinational.
- Index: on an edge with tick=1, index <= (index==NUM_DIGITS-1) ? 0 : index+1.
- Buffering: load=1 at an edge copies data/dp_in/blank to pending and sets pend=1.
  - On the tick edge where index wraps to 0: if pend=1, active <= pending, pend cleared; frame_start=1 for the next cycle. This also applies when pend=0, in which case active is unchanged.
  - load on that same edge: active takes the old pending contents; the new values go to pending and pend stays 1.
  - Multiple loads within a frame: the last one wins.
- Digit visibility for slot k (from active buffer): visible = !blank[k] && !(lz_en && k!=0 && all nibbles k..NUM_DIGITS-1 are 0). Digit 0 is never zero-suppressed.
- PWM: on = (prescaler[DIV_BITS-1 -: 4] < bright). bright=0 gives fully off; bright=15 gives 15/16 duty.
- Outputs are registered every cycle from the current index and prescaler, so they lag index by one clock.
  - If visible && on: segm_sel bit index = 0, all other bits 1; digit = font(nibble) with bit0 cleared if dp lit.
  - Otherwise: segm_sel=all 1s, digit=8'hFF.
- Font (hex, dp off): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 b:C1 C:63 d:85 E:61 F:71.
- Scan order: digit 0, 1, …, NUM_DIGITS-1, then wrap. segm_sel never has more than one bit low.

Test Plan:
1. NUM_DIGITS=4, DIV_BITS=4, hold reset=0 for 3 clocks -> segm_sel=4'b1111, digit=8'hFF, pend=0. After release, the first tick occurs at clock 15 and index=1 from clock 16.
2. load data=16'h12AF, dp_in=4'b0010, bright=15, blank=0 -> pend=1 until the index wraps to 0, then frame_start pulses. The slots show segm_sel 1110/digit 71, 1101/digit 10 (A with dp), 1011/digit 25, 0111/digit 9F. Anode is low for prescaler 0..14 and high at 15.
3. lz_en=1, data=16'h0070 -> digits 3 and 2 stay segm_sel=1111/digit FF, digit 1=1F, digit 0=03. With data=16'h0000 only digit 0 lights (03). With blank=4'b0001, digit 0 also stays dark.
4. bright=4, data=16'h8888 -> each slot has anode low for 4 of every 16 clocks (prescaler upper nibble 0..3). bright=0 -> segm_sel=1111 for a full frame.
5. Two loads mid-frame (16'h1111, then 16'h2222) -> display is unchanged until frame_start, then shows 2222. A load on the wrap edge leaves pend=1 and displays at the following frame.
6. reset=0 during the digit-2 slot -> the next clock gives segm_sel=1111, digit=FF, index=0, pend=0. After release, digit 0 displays 03 (active buffer = 0).
